branch_prediction_unit: RTL
===========================

// Module: branch_prediction_unit
// PURPOSE
//  Dynamic branch predictor for the Aquila RV32IM core, and the producer of the branch-hit and misprediction information that the pipeline flush/stall logic consumes.
//  - Fetch: a direct-mapped BHT/BTB (2-bit saturating counters + target) is looked up with the IF PC. The lookup drives taken/target into the PC mux.
//  - Execute: the resolved branch trains the table, and the block flags conditional mispredictions.
// PARAMETERS
//  XLEN       32  address width
//  ENTRY_NUM  64  table entries; power of two >= 2; IDX=log2(ENTRY_NUM)
// PORTS
//  clk_i                     in   1     core clock
//  rst_ni                    in   1     asynchronous reset, active low
//  stall_i                   in   1     pipeline stall; freezes training and statistics
//  pc_IF_i                   in   XLEN  fetch-stage PC to predict
//  bp_hit_o                  out  1     valid entry whose tag matches pc_IF_i
//  bp_taken_o                out  1     predicted taken (hit & counter[1])
//  bp_target_o               out  XLEN  predicted target; 0 when !bp_hit_o
//  exe_valid_i               in   1     EXE holds a resolved cond/uncond branch this cycle
//  exe_is_cond_i             in   1     1=conditional branch, 0=JAL/JALR
//  exe_pc_i                  in   XLEN  PC of the EXE branch
//  exe_taken_i               in   1     actual outcome
//  exe_target_i              in   XLEN  actual target
//  exe_pred_taken_i          in   1     bp_taken_o carried down the pipeline with the instruction
//  exe_pred_target_i         in   XLEN  bp_target_o carried down the pipeline
//  cond_branch_misprediction_o out 1    EXE conditional branch mispredicted (combinational)
//  stat_branch_cnt_o         out  32    resolved branches since reset
//  stat_mispredict_cnt_o     out  32    mispredicted branches (cond + uncond) since reset
// BEHAVIOUR
//  Indexing: idx=pc[IDX+1:2], tag=pc[XLEN-1:IDX+2]. pc[1:0] are ignored.
//  Entry state: valid, tag, target[XLEN], ctr[2]. The table is held in flops, not BRAM.
//  Reset (rst_ni=0, async): all valid=0, ctr=2'b01, stat counters=0.
//    - With the table empty, bp_hit_o/bp_taken_o/bp_target_o read 0 after reset.
//    - Reset asserted mid-operation discards all training immediately.
//  Lookup: purely combinational from current table state; zero-cycle latency.
//  Training (posedge, when exe_valid_i & !stall_i):
//    - Entry hit (valid & tag==exe tag):
//        - Cond: ctr saturating +1 if taken, -1 if not. Never wraps 11->00 or 00->11.
//        - Uncond: ctr forced to 2'b11.
//        - If taken, target<=exe_target_i.
//    - Entry miss and exe_taken_i: allocate (replace) the entry.
//        - valid=1, tag, target<=exe_target_i.
//        - ctr=2'b10 for cond, 2'b11 for uncond.
//    - Entry miss and not taken: table unchanged (no allocation).
//  Same-index lookup and training in one cycle: the lookup returns the pre-update entry (no bypass). The new value is visible from the next cycle.
//  stall_i=1: no table or statistic update. The lookup is still driven.
//  cond_branch_misprediction_o = exe_valid_i & exe_is_cond_i & ((exe_pred_taken_i^exe_taken_i) | (exe_taken_i & exe_pred_target_i!=exe_target_i)).
//    - Asserted regardless of stall_i; it must be 0 whenever !exe_valid_i.
//  Uncond mispredict (for statistics only): !exe_pred_taken_i | exe_pred_target_i!=exe_target_i.
//  Statistics: increment on training cycles; saturate at 32'hFFFF_FFFF.
// TESTING
//  1 Reset, then pc_IF_i=0x100 -> bp_hit_o=0, bp_taken_o=0, bp_target_o=0; both stat counters 0.
//  2 Cond branch at pc=0x100 resolved taken to 0x80 with pred_taken=0:
//    - Same cycle: misprediction_o=1.
//    - Next cycle, lookup 0x100: hit=1, taken=1, target=0x80; stat counts 1/1.
//  3 Training, ctr saturation (same branch, ENTRY_NUM=64):
//    - Taken three more times -> ctr=11.
//    - Then not-taken once -> ctr=10, still predicts taken.
//    - Not-taken again -> ctr=01, bp_taken_o=0 while bp_hit_o=1.
//  4 Aliasing: pc=0x100 is resident; a taken branch at 0x200 allocates the same idx (0x100+64*4).
//    -> lookup 0x100 hit=0; lookup 0x200 hit=1.
//  5 Stall and misprediction gating:
//    - Training request with stall_i=1 -> table and stats unchanged, yet the misprediction output is still evaluated.
//    - exe_valid_i=0 -> misprediction_o=0.
//  6 Async reset pulse mid-training -> all entries invalid at once; the first post-reset lookup misses.

Source files
------------

// File: rtl/branch_prediction_unit.sv
// Dynamic branch predictor: direct-mapped BHT/BTB held in flops.
//
// Fetch side: pc_IF_i is looked up combinationally and drives bp_hit_o, bp_taken_o and
// bp_target_o (target reads 0 on a miss).
// Execute side: a resolved branch (exe_valid_i, !stall_i) trains the addressed entry and
// the statistic counters. cond_branch_misprediction_o flags a mispredicted conditional
// branch in EXE, independent of stall_i.
//
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   stall_i                          freezes training and statistics
//   pc_IF_i                          fetch PC to predict
//   bp_hit_o/bp_taken_o/bp_target_o  prediction
//   exe_*_i                          resolved branch information from EXE
//   cond_branch_misprediction_o      conditional mispredict in EXE
//   stat_branch_cnt_o                resolved branches since reset (saturating)
//   stat_mispredict_cnt_o            mispredicted branches since reset (saturating)
module branch_prediction_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ENTRY_NUM = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic [XLEN-1:0] pc_IF_i,
  output logic            bp_hit_o,
  output logic            bp_taken_o,
  output logic [XLEN-1:0] bp_target_o,
  input  logic            exe_valid_i,
  input  logic            exe_is_cond_i,
  input  logic [XLEN-1:0] exe_pc_i,
  input  logic            exe_taken_i,
  input  logic [XLEN-1:0] exe_target_i,
  input  logic            exe_pred_taken_i,
  input  logic [XLEN-1:0] exe_pred_target_i,
  output logic            cond_branch_misprediction_o,
  output logic [31:0]     stat_branch_cnt_o,
  output logic [31:0]     stat_mispredict_cnt_o
);

  localparam int unsigned Idx  = $clog2(ENTRY_NUM);
  localparam int unsigned TagW = XLEN - Idx - 2;

  logic            valid_q  [ENTRY_NUM];
  logic            valid_d  [ENTRY_NUM];
  logic [TagW-1:0] tag_q    [ENTRY_NUM];
  logic [TagW-1:0] tag_d    [ENTRY_NUM];
  logic [XLEN-1:0] target_q [ENTRY_NUM];
  logic [XLEN-1:0] target_d [ENTRY_NUM];
  logic [1:0]      ctr_q    [ENTRY_NUM];
  logic [1:0]      ctr_d    [ENTRY_NUM];

  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  logic [Idx-1:0]  if_idx;
  logic [TagW-1:0] if_tag;
  logic [Idx-1:0]  exe_idx;
  logic [TagW-1:0] exe_tag;
  logic            exe_hit;
  logic            train_en;
  logic            cond_mis;
  logic            uncond_mis;
  logic            any_mis;

  assign if_idx  = pc_IF_i[Idx+1:2];
  assign if_tag  = pc_IF_i[XLEN-1:Idx+2];
  assign exe_idx = exe_pc_i[Idx+1:2];
  assign exe_tag = exe_pc_i[XLEN-1:Idx+2];

  // Lookup reads current state only; training in the same cycle is not bypassed.
  always_comb begin
    bp_hit_o    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    bp_taken_o  = bp_hit_o && ctr_q[if_idx][1];
    bp_target_o = bp_hit_o ? target_q[if_idx] : '0;
  end

  assign exe_hit  = valid_q[exe_idx] && (tag_q[exe_idx] == exe_tag);
  assign train_en = exe_valid_i && !stall_i;

  assign cond_mis   = (exe_pred_taken_i ^ exe_taken_i) ||
                      (exe_taken_i && (exe_pred_target_i != exe_target_i));
  assign uncond_mis = !exe_pred_taken_i || (exe_pred_target_i != exe_target_i);
  assign any_mis    = exe_is_cond_i ? cond_mis : uncond_mis;

  assign cond_branch_misprediction_o = exe_valid_i && exe_is_cond_i && cond_mis;

  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      valid_d[i]  = valid_q[i];
      tag_d[i]    = tag_q[i];
      target_d[i] = target_q[i];
      ctr_d[i]    = ctr_q[i];
    end
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;

    if (train_en) begin
      if (exe_hit) begin
        if (!exe_is_cond_i) begin
          ctr_d[exe_idx] = 2'b11;
        end else if (exe_taken_i) begin
          if (ctr_q[exe_idx] != 2'b11) ctr_d[exe_idx] = ctr_q[exe_idx] + 2'b01;
        end else begin
          if (ctr_q[exe_idx] != 2'b00) ctr_d[exe_idx] = ctr_q[exe_idx] - 2'b01;
        end
        if (exe_taken_i) target_d[exe_idx] = exe_target_i;
      end else if (exe_taken_i) begin
        // Replace whatever occupied this index.
        valid_d[exe_idx]  = 1'b1;
        tag_d[exe_idx]    = exe_tag;
        target_d[exe_idx] = exe_target_i;
        ctr_d[exe_idx]    = exe_is_cond_i ? 2'b10 : 2'b11;
      end

      if (br_cnt_q != 32'hFFFF_FFFF) br_cnt_d = br_cnt_q + 32'd1;
      if (any_mis && (mis_cnt_q != 32'hFFFF_FFFF)) mis_cnt_d = mis_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        valid_q[i]  <= valid_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign stat_branch_cnt_o     = br_cnt_q;
  assign stat_mispredict_cnt_o = mis_cnt_q;

endmodule
